// File: rtl/skew_pulse_gen_if.sv
// Control/status and waveform bundle for skew_pulse_gen.
interface skew_pulse_gen_if;
  logic [31:0] delay_bcd;
  logic        load;
  logic        sign0;
  logic        sign1;
  logic        busy;
  logic        err;
  logic [26:0] delay_bin;

  modport master (
    output delay_bcd, load,
    input  sign0, sign1, busy, err, delay_bin
  );

  modport slave (
    input  delay_bcd, load,
    output sign0, sign1, busy, err, delay_bin
  );
endinterface

// File: rtl/skew_pulse_gen.sv
// Two-channel square-wave generator whose sign1 rising edge trails sign0 by a
// BCD-programmed cycle count, applied at the next period boundary.
module skew_pulse_gen #(
  parameter int unsigned PERIOD      = 100000,
  parameter int unsigned HIGH_CYCLES = 50000
) (
  input logic              clk_100M,
  input logic              rst,
  skew_pulse_gen_if.slave  bus
);

  localparam int unsigned CW = 27;
  localparam int unsigned DW = 28;
  localparam int unsigned BW = 32;
  localparam int unsigned ND = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CONV,
    S_RANGE,
    S_PEND
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   pcnt_q;
  logic [CW-1:0]   d_act_q;
  logic [CW-1:0]   acc_q;
  logic [CW-1:0]   delay_bin_q;
  logic [BW-1:0]   bcd_q;
  logic [2:0]      dig_q;
  logic            sign0_q;
  logic            sign1_q;
  logic            busy_q;
  logic            err_q;

  logic            pcnt_wrap;
  logic [DW-1:0]   diff;
  logic [DW-1:0]   diff_mod;
  logic            bcd_bad;
  logic [3:0]      digit;
  logic [CW-1:0]   acc_nxt;

  assign pcnt_wrap = (pcnt_q == CW'(PERIOD - 1));

  // Phase of sign1 relative to its own period, folded back into 0..PERIOD-1.
  assign diff     = {1'b0, pcnt_q} - {1'b0, d_act_q};
  assign diff_mod = diff[DW-1] ? (diff + DW'(PERIOD)) : diff;

  assign digit   = bcd_q[{dig_q, 2'b00} +: 4];
  assign acc_nxt = (acc_q << 3) + (acc_q << 1) + CW'(digit);

  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (bcd_q[i*4 +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end

  // Free-running period counter and the two waveform flops.
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      pcnt_q  <= '0;
      sign0_q <= 1'b0;
      sign1_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_wrap ? '0 : pcnt_q + CW'(1);
      sign0_q <= (pcnt_q < CW'(HIGH_CYCLES));
      sign1_q <= (diff_mod < DW'(HIGH_CYCLES));
    end
  end

  // Load: validate, convert MS digit first, range-check, then wait for the wrap.
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bcd_q       <= '0;
      acc_q       <= '0;
      dig_q       <= '0;
      d_act_q     <= '0;
      delay_bin_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.load) begin
            bcd_q   <= bus.delay_bcd;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (bcd_bad) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            dig_q   <= 3'd7;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          acc_q <= acc_nxt;
          if (dig_q == 3'd0) state_q <= S_RANGE;
          else               dig_q   <= dig_q - 3'd1;
        end
        S_RANGE: begin
          if ({1'b0, acc_q} >= DW'(PERIOD)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            delay_bin_q <= acc_q;
            err_q       <= 1'b0;
            state_q     <= S_PEND;
          end
        end
        S_PEND: begin
          // Swap on the last cycle of a period so the next one starts clean.
          if (pcnt_wrap) begin
            d_act_q <= delay_bin_q;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.sign0     = sign0_q;
  assign bus.sign1     = sign1_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.delay_bin = delay_bin_q;

endmodule
